// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Purpose  : Round-robin merger of N_CH FWFT source FIFOs into one 32-bit
//            FWFT stream with a one-word registered output stage. Each grant
//            is a burst of up to BURST_MAX words (0 = unlimited).
// Revision : 1.0  initial release
// ============================================================================
module stream_rr_arbiter #(
    parameter int N_CH      = 4,
    parameter int BURST_MAX = 16,
    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST_N,
    input  logic [N_CH-1:0]     CH_ENABLE,
    input  logic [N_CH-1:0]     CH_FIFO_EMPTY,
    input  logic [32*N_CH-1:0]  CH_FIFO_DATA,
    output logic [N_CH-1:0]     CH_FIFO_READ,
    input  logic                FIFO_READ_NEXT,
    output logic                FIFO_EMPTY,
    output logic [31:0]         FIFO_DATA,
    output logic                GRANT_VALID,
    output logic [CW-1:0]       GRANT_CH
);

    localparam int CNTW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   grant_ch_q, grant_ch_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;

    logic [N_CH-1:0] w_cand;
    logic            w_found;
    logic [CW-1:0]   w_winner;
    logic [CW-1:0]   w_scan;
    logic            w_sel_en;
    logic            w_sel_empty;
    logic [31:0]     w_sel_data;
    logic            w_load;
    logic            w_burst_done;
    logic            w_release;

    // A channel may win arbitration only when enabled and holding data.
    assign w_cand = CH_ENABLE & ~CH_FIFO_EMPTY;

    // Rotating search starting one past the last granted channel.
    always_comb begin
        w_found  = 1'b0;
        w_winner = last_q;
        w_scan   = last_q;
        for (int k = 0; k < N_CH; k++) begin
            w_scan = (w_scan == CW'(N_CH - 1)) ? '0 : w_scan + 1'b1;
            if (!w_found && w_cand[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    // Pick out the flags and head word of the granted channel.
    always_comb begin
        w_sel_en    = 1'b0;
        w_sel_empty = 1'b1;
        w_sel_data  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_ch_q == CW'(i)) begin
                w_sel_en    = CH_ENABLE[i];
                w_sel_empty = CH_FIFO_EMPTY[i];
                w_sel_data  = CH_FIFO_DATA[32*i +: 32];
            end
        end
    end

    // Transfer one word whenever the output slot is free or being vacated.
    assign w_load = (state_q == GRANT) && w_sel_en && !w_sel_empty &&
                    (!out_valid_q || FIFO_READ_NEXT);

    generate
        if (BURST_MAX > 0) begin : g_burst_limit
            logic [CNTW-1:0] w_cnt_inc;
            assign w_cnt_inc    = cnt_q + 1'b1;
            assign w_burst_done = (w_cnt_inc == CNTW'(BURST_MAX));
        end else begin : g_burst_unlimited
            assign w_burst_done = 1'b0;
        end
    endgenerate

    // A stalled but still eligible channel keeps its grant.
    assign w_release = w_load ? w_burst_done : (w_sel_empty || !w_sel_en);

    // Pop strobe goes only to the granted channel on a load.
    always_comb begin
        CH_FIFO_READ = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_load && (grant_ch_q == CW'(i))) begin
                CH_FIFO_READ[i] = 1'b1;
            end
        end
    end

    // Next-state for the arbiter FSM, burst counter and output register.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_ch_d  = grant_ch_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d    = GRANT;
                    last_d     = w_winner;
                    grant_ch_d = w_winner;
                    cnt_d      = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_load) begin
            out_data_d  = w_sel_data;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
        end else if (FIFO_READ_NEXT && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; channel 0 has first priority out of reset.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q     <= IDLE;
            last_q      <= CW'(N_CH - 1);
            grant_ch_q  <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_ch_q  <= grant_ch_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign FIFO_EMPTY  = !out_valid_q;
    assign FIFO_DATA   = out_data_q;
    assign GRANT_VALID = (state_q == GRANT);
    assign GRANT_CH    = grant_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Purpose  : Self-checking bench for stream_rr_arbiter: directed scenarios
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_rr_arbiter;

    localparam int N_CH      = 4;
    localparam int BURST_MAX = 16;
    localparam int CW        = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH-1:0]      ch_en;
    logic [N_CH-1:0]      ch_empty;
    logic [32*N_CH-1:0]   ch_data;
    logic [N_CH-1:0]      ch_read;
    logic                 rn;
    logic                 f_empty;
    logic [31:0]          f_data;
    logic                 gv;
    logic [CW-1:0]        gch;
    logic [N_CH-1:0]      ch_read_u;
    logic                 f_empty_u;
    logic [31:0]          f_data_u;
    logic                 gv_u;
    logic [CW-1:0]        gch_u;

    int n_tests = 0;
    int n_fail  = 0;

    // Source FIFO contents seen by the DUT, and the model's own copy.
    logic [31:0] src_q [N_CH][$];
    logic [31:0] mdl_q [N_CH][$];
    logic [N_CH-1:0] last_rd;

    // Reference model state (transaction level).
    bit              m_grant;
    bit              m_ov;
    int              m_ch;
    int              m_last;
    int              m_cnt;
    logic [31:0]     m_od;
    logic [N_CH-1:0] m_exp_rd;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N_CH(N_CH), .BURST_MAX(BURST_MAX)) dut (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_ENABLE(ch_en),
        .CH_FIFO_EMPTY(ch_empty), .CH_FIFO_DATA(ch_data), .CH_FIFO_READ(ch_read),
        .FIFO_READ_NEXT(rn), .FIFO_EMPTY(f_empty), .FIFO_DATA(f_data),
        .GRANT_VALID(gv), .GRANT_CH(gch)
    );

    stream_rr_arbiter #(.N_CH(N_CH), .BURST_MAX(0)) u_unl (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_ENABLE(ch_en),
        .CH_FIFO_EMPTY(ch_empty), .CH_FIFO_DATA(ch_data), .CH_FIFO_READ(ch_read_u),
        .FIFO_READ_NEXT(rn), .FIFO_EMPTY(f_empty_u), .FIFO_DATA(f_data_u),
        .GRANT_VALID(gv_u), .GRANT_CH(gch_u)
    );

    task automatic drive_src();
        for (int i = 0; i < N_CH; i++) begin
            ch_empty[i]         = (src_q[i].size() == 0);
            ch_data[32*i +: 32] = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
        end
    endtask

    task automatic push(input int ch, input logic [31:0] w);
        src_q[ch].push_back(w);
        mdl_q[ch].push_back(w);
    endtask

    task automatic model_reset();
        m_grant  = 1'b0;
        m_ov     = 1'b0;
        m_ch     = 0;
        m_last   = N_CH - 1;
        m_cnt    = 0;
        m_od     = 32'h0;
        m_exp_rd = '0;
    endtask

    // One clock of the arbitration rules applied to the current inputs.
    task automatic model_step();
        bit ld;
        bit found;
        int w;
        ld = m_grant && ch_en[m_ch] && (mdl_q[m_ch].size() > 0) && (!m_ov || rn);
        m_exp_rd = '0;
        if (ld) m_exp_rd[m_ch] = 1'b1;
        if (!m_grant) begin
            found = 1'b0;
            for (int k = 1; k <= N_CH; k++) begin
                w = (m_last + k) % N_CH;
                if (!found && ch_en[w] && mdl_q[w].size() > 0) begin
                    found   = 1'b1;
                    m_grant = 1'b1;
                    m_ch    = w;
                    m_last  = w;
                    m_cnt   = 0;
                end
            end
        end else if (ld) begin
            m_cnt++;
            if (BURST_MAX != 0 && m_cnt == BURST_MAX) m_grant = 1'b0;
        end else if (!ch_en[m_ch] || mdl_q[m_ch].size() == 0) begin
            m_grant = 1'b0;
        end
        if (ld) begin
            m_od = mdl_q[m_ch].pop_front();
            m_ov = 1'b1;
        end else if (rn && m_ov) begin
            m_ov = 1'b0;
        end
    endtask

    // Advance one clock: called at a negedge with inputs set, returns at the next negedge.
    task automatic tick();
        #1;
        last_rd = ch_read;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (last_rd[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_src();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rn    = 1'b0;
        ch_en = '1;
        for (int i = 0; i < N_CH; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
        drive_src();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rn = 1'b0; ch_en = '1; ch_empty = '1; ch_data = '0;
        #1;
        n_tests++;
        if (f_empty !== 1'b1 || gv !== 1'b0 || gch !== 2'd0 || f_data !== 32'h0 || ch_read !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_values: empty=%b gv=%b gch=%0d data=%h rd=%b, required 1 0 0 0 0000",
                     f_empty, gv, gch, f_data, ch_read);
        end
        do_reset();
        rn = 1'b1;
        for (int k = 0; k < 20; k++) push(0, 32'h0000_0100 + k);
        drive_src();
        repeat (4) tick();
        for (int k = 0; k < 20; k++) push(2, 32'h2000_0100 + k);
        drive_src();
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (f_empty !== 1'b1 || ch_read !== 4'h0 || gv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midburst: empty=%b rd=%b gv=%b, required 1 0000 0", f_empty, ch_read, gv);
        end
        model_reset();
        for (int i = 0; i < N_CH; i++) mdl_q[i] = src_q[i];
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (gv !== 1'b1 || gch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: gv=%b gch=%0d, required 1 0", gv, gch);
        end
    endtask

    task automatic test_single();
        do_reset();
        rn = 1'b1;
        for (int k = 0; k < 5; k++) push(1, 32'hA0 + k);
        drive_src();
        tick();
        n_tests++;
        if (f_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency1: empty=%b, required 1", f_empty);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (f_empty !== 1'b0 || f_data !== 32'hA0 + k) begin
                n_fail++;
                $display("FAIL single_word%0d: empty=%b data=%h, required 0 %h", k, f_empty, f_data, 32'hA0 + k);
            end
            tick();
        end
        n_tests++;
        if (f_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_drained: empty=%b, required 1", f_empty);
        end
    endtask

    task automatic test_fairness();
        logic [31:0] got[$];
        int          gcyc[$];
        logic [31:0] exp_q[$];
        int bch[6] = '{0, 3, 0, 3, 0, 3};
        int bst[6] = '{0, 0, 16, 16, 32, 32};
        int bln[6] = '{16, 16, 16, 16, 8, 8};
        int bad;
        do_reset();
        rn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            push(0, {4'h0, 28'(k)});
            push(3, {4'h3, 28'(k)});
        end
        drive_src();
        for (int cyc = 0; cyc < 300 && got.size() < 80; cyc++) begin
            if (!f_empty) begin
                got.push_back(f_data);
                gcyc.push_back(cyc);
            end
            tick();
        end
        for (int b = 0; b < 6; b++)
            for (int k = 0; k < bln[b]; k++) exp_q.push_back({4'(bch[b]), 28'(bst[b] + k)});
        n_tests++;
        if (got.size() != 80) begin
            n_fail++;
            $display("FAIL fair_count: got %0d words, required 80", got.size());
        end else begin
            bad = -1;
            for (int i = 79; i >= 0; i--) if (got[i] !== exp_q[i]) bad = i;
            n_tests++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL fair_order: word %0d = %h, required %h", bad, got[bad], exp_q[bad]);
            end
            for (int j = 16; j <= 48; j += 16) begin
                n_tests++;
                if (gcyc[j] - gcyc[j-1] != 2) begin
                    n_fail++;
                    $display("FAIL fair_gap@%0d: spacing %0d cycles, required 2", j, gcyc[j] - gcyc[j-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic [31:0] held;
        int first_gap = -1;
        do_reset();
        rn = 1'b1;
        for (int k = 0; k < 30; k++) push(1, 32'h1000_0000 + k);
        drive_src();
        repeat (5) begin
            if (!f_empty && rn) got.push_back(f_data);
            if (got.size() > 0 && f_empty && first_gap < 0) first_gap = got.size();
            tick();
        end
        rn   = 1'b0;
        held = f_data;
        n_tests++;
        if (held !== 32'h1000_0003) begin
            n_fail++;
            $display("FAIL bp_held_word: data=%h, required 10000003", held);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (last_rd !== 4'h0 || f_data !== 32'h1000_0003 || f_empty !== 1'b0 || gv !== 1'b1 || gch !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_stall%0d: rd=%b data=%h empty=%b gv=%b gch=%0d, required 0000 10000003 0 1 1",
                         c, last_rd, f_data, f_empty, gv, gch);
            end
        end
        rn = 1'b1;
        for (int c = 0; c < 200 && got.size() < 30; c++) begin
            if (!f_empty && rn) got.push_back(f_data);
            if (got.size() > 0 && f_empty && first_gap < 0) first_gap = got.size();
            tick();
        end
        n_tests++;
        if (got.size() != 30) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words, required 30", got.size());
        end else begin
            for (int k = 0; k < 30; k++) begin
                n_tests++;
                if (got[k] !== 32'h1000_0000 + k) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: %h, required %h", k, got[k], 32'h1000_0000 + k);
                end
            end
        end
        n_tests++;
        if (first_gap != 16) begin
            n_fail++;
            $display("FAIL bp_burst_len: first gap after %0d words, required 16", first_gap);
        end
    endtask

    task automatic test_disable();
        do_reset();
        rn = 1'b1;
        for (int k = 0; k < 20; k++) push(2, 32'h2000_0000 + k);
        drive_src();
        for (int c = 0; c < 100 && src_q[2].size() > 6; c++) tick();
        n_tests++;
        if (f_empty !== 1'b0 || f_data !== 32'h2000_000D || gv !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_pre: empty=%b data=%h gv=%b, required 0 2000000d 1", f_empty, f_data, gv);
        end
        ch_en[2] = 1'b0;
        rn       = 1'b0;
        tick();
        n_tests++;
        if (last_rd !== 4'h0 || gv !== 1'b0 || f_empty !== 1'b0 || f_data !== 32'h2000_000D) begin
            n_fail++;
            $display("FAIL dis_release: rd=%b gv=%b empty=%b data=%h, required 0000 0 0 2000000d",
                     last_rd, gv, f_empty, f_data);
        end
        rn = 1'b1;
        tick();
        n_tests++;
        if (last_rd !== 4'h0 || f_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_drain: rd=%b empty=%b, required 0000 1", last_rd, f_empty);
        end
        repeat (3) tick();
        n_tests++;
        if (src_q[2].size() != 6 || gv !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_left: queued=%0d gv=%b, required 6 0", src_q[2].size(), gv);
        end
    endtask

    task automatic test_random();
        int seqn[N_CH];
        int idx;
        do_reset();
        for (int i = 0; i < N_CH; i++) seqn[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_tests++;
            if (f_empty !== !m_ov || f_data !== m_od || gv !== m_grant || gch !== CW'(m_ch)) begin
                n_fail++;
                $display("FAIL rand_state@%0d: empty=%b data=%h gv=%b gch=%0d, required %b %h %b %0d",
                         cyc, f_empty, f_data, gv, gch, !m_ov, m_od, m_grant, m_ch);
            end
            if (cyc < 2500) begin
                for (int c = 0; c < N_CH; c++) begin
                    if ($urandom_range(0, 2) == 0 && src_q[c].size() < 24) begin
                        push(c, {4'(c), 28'(seqn[c])});
                        seqn[c]++;
                    end
                end
                if ($urandom_range(0, 39) == 0) begin
                    idx = int'($urandom_range(0, N_CH - 1));
                    ch_en[idx] = ~ch_en[idx];
                end
            end else begin
                ch_en = '1;
            end
            rn = ($urandom_range(0, 3) != 0);
            drive_src();
            tick();
            n_tests++;
            if (last_rd !== m_exp_rd) begin
                n_fail++;
                $display("FAIL rand_read@%0d: rd=%b, required %b", cyc, last_rd, m_exp_rd);
            end
        end
    endtask

    task automatic test_unlimited();
        int cnt2      = 0;
        bit ch0_seen  = 1'b0;
        bit early0    = 1'b0;
        bit grant_brk = 1'b0;
        int cyc       = 0;
        do_reset();
        rn       = 1'b1;
        ch_en    = '1;
        ch_empty = 4'b1011;
        ch_data  = '0;
        while (cyc < 400 && !ch0_seen) begin
            #1;
            if (ch_read_u[2]) cnt2++;
            if (ch_read_u[0]) begin
                ch0_seen = 1'b1;
                if (cnt2 < 100) early0 = 1'b1;
            end
            if (cnt2 > 0 && cnt2 < 100 && !gv_u) grant_brk = 1'b1;
            @(posedge clk);
            #1;
            ch_empty[2]      = (cnt2 >= 100);
            ch_empty[0]      = (cnt2 == 0);
            ch_data[95:64]   = 32'(cnt2);
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (!ch0_seen) begin
            n_fail++;
            $display("FAIL unl_ch0_granted: ch0 never read within 400 cycles, required a read");
        end
        n_tests++;
        if (cnt2 != 100 || early0) begin
            n_fail++;
            $display("FAIL unl_burst: ch2 reads=%0d early_ch0=%b, required 100 0", cnt2, early0);
        end
        n_tests++;
        if (grant_brk) begin
            n_fail++;
            $display("FAIL unl_single_grant: grant dropped during ch2 burst, required held");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_disable();
        test_random();
        test_unlimited();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin merger that drains up to N_CH first-word-fall-through (FWFT) source FIFOs into one 32-bit FWFT stream. It sits directly upstream of the BRAM readout FIFO core and presents exactly the READ_NEXT / EMPTY / DATA handshake that the core's FIFO-side inputs consume. Each grant is a burst of words from one channel, and grants rotate fairly among enabled, non-empty channels. A one-word output register gives full throughput with a registered output.

## Interface
- N_CH, 4: number of source channels, legal range 1..8.
- BURST_MAX, 16: maximum words per grant; 0 means unlimited (grant held until the channel empties or is disabled).
- CW, derived: $clog2(N_CH), minimum 1; width of GRANT_CH.

- BUS_CLK  in  1  single clock for the whole block.
- BUS_RST_N  in  1  asynchronous, active-low reset.
- CH_ENABLE  in  N_CH  per-channel enable mask.
- CH_FIFO_EMPTY  in  N_CH  source FIFO empty flags (FWFT).
- CH_FIFO_DATA  in  32*N_CH  source data; channel i occupies [32i+31:32i].
- CH_FIFO_READ  out  N_CH  one-cycle read/pop strobe per channel; at most one bit high per cycle.
- FIFO_READ_NEXT  in  1  consumer pop; connects to the readout FIFO core's FIFO_READ_NEXT_OUT.
- FIFO_EMPTY  out  1  merged stream empty flag; high when the output register holds no word.
- FIFO_DATA  out  32  merged stream word; valid while FIFO_EMPTY is low.
- GRANT_VALID  out  1  a channel currently holds the grant.
- GRANT_CH  out  CW  index of the granted or last-granted channel.

## Operation
- The FSM has two states, IDLE and GRANT. A register `last` holds the index of the most recently granted channel.
- IDLE:
  - Candidates are channels with CH_ENABLE=1 and CH_FIFO_EMPTY=0.
  - The search starts at last+1 mod N_CH and wraps; the first candidate found wins.
  - On a win, GRANT_CH and `last` are set to the winner, GRANT_VALID is set to 1, the burst counter is cleared, and the FSM moves to GRANT.
  - With no candidate, the FSM stays in IDLE.
- Output register: holds out_valid and out_data. FIFO_EMPTY = !out_valid and FIFO_DATA = out_data.
- load = GRANT && CH_ENABLE[g] && !CH_FIFO_EMPTY[g] && (!out_valid || FIFO_READ_NEXT).
  - On load: CH_FIFO_READ[g]=1 in the same cycle, out_data <= CH_FIFO_DATA[g], out_valid <= 1, and the burst counter increments.
  - FIFO_READ_NEXT && out_valid && !load: out_valid <= 0.
  - FIFO_READ_NEXT while out_valid=0 is ignored; no state changes.
- GRANT release. Evaluated each cycle; on release the next state is IDLE and GRANT_VALID <= 0:
  - load, and counter+1 == BURST_MAX (BURST_MAX != 0).
  - no load, and either CH_FIFO_EMPTY[g]=1 or CH_ENABLE[g]=0.
- GRANT hold: no load only because the output is stalled (out_valid && !FIFO_READ_NEXT) while the channel is enabled and non-empty. The grant is kept and the counter is unchanged.
- A word already in the output register is always delivered, even if its channel is disabled afterwards.
- Burst counter width is $clog2(BURST_MAX+1), minimum 1. With BURST_MAX=0 the counter is not compared and may wrap freely.
- Reset values (async assert, sync release):
  - state=IDLE, last=N_CH-1 so channel 0 has first priority.
  - out_valid=0, so FIFO_EMPTY=1; FIFO_DATA=0.
  - CH_FIFO_READ=0, GRANT_VALID=0, GRANT_CH=0, counter=0.

## Timing
- CH_FIFO_READ is combinational from registered state and inputs. All other outputs are registered.
- Arbitration latency: a candidate visible in IDLE at cycle t gives GRANT at t+1. The first load can occur at t+1, so FIFO_EMPTY goes low at t+2.
- Throughput within a burst is 1 word/cycle with FIFO_READ_NEXT held high.
- There is exactly one cycle with no load between consecutive grants (the IDLE cycle).
- Pop and load in the same cycle replace the output word with no bubble.
- Ordering: words from a single channel leave in source order. Bursts never interleave.
- Reset mid-burst: outputs take their reset values immediately on assertion. Any word held in the output register is lost. Source FIFOs are not popped after assertion.

## Test plan
- Reset: assert BUS_RST_N=0 mid-traffic -> within the same cycle FIFO_EMPTY=1, CH_FIFO_READ=0, GRANT_VALID=0. After release, channel 0 is granted first when channels 0 and 2 are both non-empty.
- Single channel: ch1 holds 5 words 0xA0..0xA4, FIFO_READ_NEXT=1 constantly -> FIFO_EMPTY low 2 cycles after ch1 becomes non-empty; 0xA0..0xA4 on 5 consecutive cycles; FIFO_EMPTY high after the last pop.
- Fairness: N_CH=4, BURST_MAX=16, ch0 and ch3 each hold 40 words, sink always ready -> sequence is ch0×16, gap 1, ch3×16, gap 1, ch0×16, ch3×16, ch0×8, ch3×8. Total 80 words, no loss or duplication.
- Backpressure: during a burst hold FIFO_READ_NEXT=0 for 10 cycles -> CH_FIFO_READ stays 0, FIFO_DATA stable, grant held, counter unchanged. On release, delivery resumes with the next source word and no gaps.
- Disable mid-burst: clear CH_ENABLE[g] with 6 words still queued -> no further CH_FIFO_READ[g]; the word in the output register is still delivered; GRANT_VALID drops the next cycle; the 6 words remain in the source.
- Unlimited burst: BURST_MAX=0, ch2 holds 100 words and ch0 holds words -> all 100 ch2 words are sent in one grant before ch0 is granted.
